// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Single-port frame-buffer arbiter. The VGA pixel fetch path has strict
// priority and a fixed 3-cycle read latency. The CPU result writer gets the
// remaining memory slots through a req/ack handshake. The block drives a
// synchronous RAM whose read data appears one cycle after the address.
//
// Ports
//   clk, rst         system clock; asynchronous active-low reset
//   disp_en          display fetch enable (low: disp_req ignored)
//   disp_req         display read request, one-cycle qualifier
//   disp_addr        display read address
//   disp_valid       display read data valid (3 cycles after disp_req)
//   disp_data        display read data
//   cpu_req          CPU request, held high until cpu_ack
//   cpu_we           1 = write, 0 = read (stable while cpu_req high)
//   cpu_addr         CPU address (stable while cpu_req high)
//   cpu_wdata        CPU write data (stable while cpu_req high)
//   cpu_ack          one-cycle completion pulse
//   cpu_rdata        CPU read data, valid with cpu_ack for reads
//   cpu_stall_cnt    saturating count of cycles the CPU lost arbitration
//   mem_addr         RAM address (registered)
//   mem_we           RAM write enable (registered)
//   mem_wdata        RAM write data (registered)
//   mem_rdata        RAM read data, one cycle after mem_addr
// -----------------------------------------------------------------------------
module fb_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_en,
  input  logic               disp_req,
  input  logic [ADDR_W-1:0]  disp_addr,
  output logic               disp_valid,
  output logic [DATA_W-1:0]  disp_data,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [ADDR_W-1:0]  cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic               cpu_ack,
  output logic [DATA_W-1:0]  cpu_rdata,
  output logic [STALL_W-1:0] cpu_stall_cnt,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WR   = 2'd1,
    C_RD1  = 2'd2,
    C_RD2  = 2'd3
  } cpu_state_e;

  cpu_state_e         r_state;
  cpu_state_e         w_state_nxt;

  logic               w_disp_win;
  logic               w_cpu_ready;
  logic               w_cpu_win;
  logic               w_stall_inc;

  logic [1:0]         r_disp_tag;
  logic               r_disp_valid;
  logic [DATA_W-1:0]  r_disp_data;
  logic               r_cpu_ack;
  logic [DATA_W-1:0]  r_cpu_rdata;
  logic [STALL_W-1:0] r_stall_cnt;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_we;
  logic [DATA_W-1:0]  r_mem_wdata;

  // ---------------------------------------------------------------------------
  // Slot grant and CPU next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    w_disp_win  = disp_en && disp_req;
    // The read-ack cycle is already back in C_IDLE, but cpu_req in that cycle
    // still belongs to the finished transaction, so it must not be granted
    // (and does not count as a stall).
    w_cpu_ready = (r_state == C_IDLE) && !r_cpu_ack;
    w_cpu_win   = cpu_req && w_cpu_ready && !w_disp_win;
    w_stall_inc = cpu_req && w_cpu_ready && w_disp_win;
    w_state_nxt = r_state;

    case (r_state)
      C_IDLE:  if (w_cpu_win) w_state_nxt = cpu_we ? C_WR : C_RD1;
      C_WR:    w_state_nxt = C_IDLE;
      C_RD1:   w_state_nxt = C_RD2;
      C_RD2:   w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CPU FSM state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      r_state <= C_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port, display pipeline, CPU completion and stall counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_disp_tag   <= 2'b00;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      // An idle slot keeps the previous address and only drops the write.
      r_mem_we <= w_cpu_win && cpu_we;
      if (w_disp_win) begin
        r_mem_addr <= disp_addr;
      end else if (w_cpu_win) begin
        r_mem_addr <= cpu_addr;
        if (cpu_we) r_mem_wdata <= cpu_wdata;
      end

      // Tag bit 1 lines up with mem_rdata for a display read issued two
      // cycles ago; in-flight reads finish even if disp_en has dropped.
      r_disp_tag   <= {r_disp_tag[0], w_disp_win};
      r_disp_valid <= r_disp_tag[1];
      if (r_disp_tag[1]) r_disp_data <= mem_rdata;

      // Write ack coincides with mem_we; read ack follows C_RD2.
      r_cpu_ack <= (w_cpu_win && cpu_we) || (r_state == C_RD2);
      if (r_state == C_RD2) r_cpu_rdata <= mem_rdata;

      if (w_stall_inc && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_W'(1);
      end
    end
  end

  assign disp_valid    = r_disp_valid;
  assign disp_data     = r_disp_data;
  assign cpu_ack       = r_cpu_ack;
  assign cpu_rdata     = r_cpu_rdata;
  assign cpu_stall_cnt = r_stall_cnt;
  assign mem_addr      = r_mem_addr;
  assign mem_we        = r_mem_we;
  assign mem_wdata     = r_mem_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//
// Self-checking bench for fb_arbiter. A behavioural RAM sits on the memory
// port (preloaded with addr[7:0]). A transaction-level model predicts, from
// the arbitration rules, when each display datum and CPU ack must appear and
// what the stall counters must read. A second DUT with STALL_W = 4 shares the
// stimulus to exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        disp_en, disp_req;
  logic [15:0] disp_addr;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;

  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [15:0] cpu_stall_cnt;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic        s_disp_valid;
  logic [7:0]  s_disp_data;
  logic        s_cpu_ack;
  logic [7:0]  s_cpu_rdata;
  logic [3:0]  s_stall;
  logic [15:0] s_mem_addr;
  logic        s_mem_we;
  logic [7:0]  s_mem_wdata;
  logic [7:0]  s_mem_rdata;
  assign s_mem_rdata = 8'h00;

  fb_arbiter dut (
    .clk(clk), .rst(rst),
    .disp_en(disp_en), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall_cnt(cpu_stall_cnt),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  fb_arbiter #(.STALL_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .disp_en(disp_en), .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_valid(s_disp_valid), .disp_data(s_disp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(s_cpu_ack), .cpu_rdata(s_cpu_rdata), .cpu_stall_cnt(s_stall),
    .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata)
  );

  // Registered 64K x 8 RAM, read-before-write, preloaded with addr[7:0].
  logic [7:0] ram [0:65535];
  bit         loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'(i);
      loaded <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  // ---------------------------------------------------------------------------
  // Counters and compare helper
  // ---------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model.
  // Future expectations are kept in an 8-entry ring indexed by cycle number.
  // ---------------------------------------------------------------------------
  logic [7:0]  ram_model [0:65535];
  int          next_free;
  int          stall_exp;
  int          stall4_exp;
  logic        exp_dv    [0:7];
  logic [7:0]  exp_dd    [0:7];
  logic        exp_ack   [0:7];
  logic        exp_isrd  [0:7];
  logic [7:0]  exp_rd    [0:7];
  logic        exp_we    [0:7];
  logic [15:0] exp_waddr [0:7];
  logic [7:0]  exp_wdata [0:7];

  task automatic clear_slot(input int s);
    exp_dv[s]  = 1'b0; exp_dd[s]   = '0;
    exp_ack[s] = 1'b0; exp_isrd[s] = 1'b0; exp_rd[s] = '0;
    exp_we[s]  = 1'b0; exp_waddr[s] = '0;  exp_wdata[s] = '0;
  endtask

  task automatic model_clear();
    for (int s = 0; s < 8; s++) clear_slot(s);
    next_free  = cyc;
    stall_exp  = 0;
    stall4_exp = 0;
  endtask

  // Applies this cycle's inputs to the model and schedules future outputs.
  task automatic model_step();
    bit disp_win, cpu_free;
    disp_win = disp_en && disp_req;
    cpu_free = (cyc >= next_free);
    if (disp_win) begin
      exp_dv[(cyc + 3) % 8] = 1'b1;
      exp_dd[(cyc + 3) % 8] = ram_model[disp_addr];
    end
    if (cpu_req && cpu_free) begin
      if (disp_win) begin
        if (stall_exp  < 65535) stall_exp++;
        if (stall4_exp < 15)    stall4_exp++;
      end else if (cpu_we) begin
        ram_model[cpu_addr]      = cpu_wdata;
        exp_ack[(cyc + 1) % 8]   = 1'b1;
        exp_we[(cyc + 1) % 8]    = 1'b1;
        exp_waddr[(cyc + 1) % 8] = cpu_addr;
        exp_wdata[(cyc + 1) % 8] = cpu_wdata;
        next_free = cyc + 2;
      end else begin
        exp_ack[(cyc + 3) % 8]  = 1'b1;
        exp_isrd[(cyc + 3) % 8] = 1'b1;
        exp_rd[(cyc + 3) % 8]   = ram_model[cpu_addr];
        next_free = cyc + 4;
      end
    end
  endtask

  task automatic check_model();
    int s;
    s = cyc % 8;
    check("model.disp_valid", disp_valid, exp_dv[s]);
    if (exp_dv[s]) check("model.disp_data", disp_data, exp_dd[s]);
    check("model.cpu_ack", cpu_ack, exp_ack[s]);
    if (exp_ack[s] && exp_isrd[s]) check("model.cpu_rdata", cpu_rdata, exp_rd[s]);
    check("model.mem_we", mem_we, exp_we[s]);
    if (exp_we[s]) begin
      check("model.mem_addr", mem_addr, exp_waddr[s]);
      check("model.mem_wdata", mem_wdata, exp_wdata[s]);
    end
    check("model.stall", cpu_stall_cnt, stall_exp);
    check("model.stall4", s_stall, stall4_exp);
    clear_slot(s);
  endtask

  // Drives one cycle of inputs, advances to the next cycle, checks the model.
  task automatic drive(input logic den, input logic dreq, input logic [15:0] daddr,
                       input logic creq, input logic cwe, input logic [15:0] caddr,
                       input logic [7:0] cwd);
    disp_en = den; disp_req = dreq; disp_addr = daddr;
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: inputs for one cycle, outputs seen in the next.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        den, dreq;
    logic [15:0] daddr;
    logic        creq, cwe;
    logic [15:0] caddr;
    logic [7:0]  cwd;
    logic        e_dv;
    logic [7:0]  e_dd;
    logic        e_ack;
    logic        e_rdchk;
    logic [7:0]  e_rd;
    logic [15:0] e_stall;
  } vec_t;

  function automatic vec_t mk(logic den, logic dreq, logic [15:0] daddr,
                              logic creq, logic cwe, logic [15:0] caddr, logic [7:0] cwd,
                              logic e_dv, logic [7:0] e_dd, logic e_ack,
                              logic e_rdchk, logic [7:0] e_rd, logic [15:0] e_stall);
    vec_t v;
    v.den = den; v.dreq = dreq; v.daddr = daddr;
    v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.e_dv = e_dv; v.e_dd = e_dd; v.e_ack = e_ack;
    v.e_rdchk = e_rdchk; v.e_rd = e_rd; v.e_stall = e_stall;
    return v;
  endfunction

  vec_t tbl [18];

  // Random-phase driver state
  logic        c_active, c_we, ack_seen, r_den;
  logic [15:0] c_addr;
  logic [7:0]  c_wd;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Write 0x1234=A5 (ack T+1), read it back (ack T+3), then a write held
    // through a 5-cycle display burst, then read-before-write ordering.
    tbl[0]  = mk(0,0,16'h0000, 1,1,16'h1234,8'hA5, 0,8'h00, 1,0,8'h00, 16'd0);
    tbl[1]  = mk(0,0,16'h0000, 1,1,16'h1234,8'hA5, 0,8'h00, 0,0,8'h00, 16'd0);
    tbl[2]  = mk(0,0,16'h0000, 1,0,16'h1234,8'h00, 0,8'h00, 0,0,8'h00, 16'd0);
    tbl[3]  = mk(0,0,16'h0000, 1,0,16'h1234,8'h00, 0,8'h00, 0,0,8'h00, 16'd0);
    tbl[4]  = mk(0,0,16'h0000, 1,0,16'h1234,8'h00, 0,8'h00, 1,1,8'hA5, 16'd0);
    tbl[5]  = mk(0,0,16'h0000, 1,0,16'h1234,8'h00, 0,8'h00, 0,0,8'h00, 16'd0);
    tbl[6]  = mk(1,1,16'h0010, 1,1,16'h0010,8'h3C, 0,8'h00, 0,0,8'h00, 16'd1);
    tbl[7]  = mk(1,1,16'h0011, 1,1,16'h0010,8'h3C, 0,8'h00, 0,0,8'h00, 16'd2);
    tbl[8]  = mk(1,1,16'h0012, 1,1,16'h0010,8'h3C, 1,8'h10, 0,0,8'h00, 16'd3);
    tbl[9]  = mk(1,1,16'h0013, 1,1,16'h0010,8'h3C, 1,8'h11, 0,0,8'h00, 16'd4);
    tbl[10] = mk(1,1,16'h0014, 1,1,16'h0010,8'h3C, 1,8'h12, 0,0,8'h00, 16'd5);
    tbl[11] = mk(1,0,16'h0014, 1,1,16'h0010,8'h3C, 1,8'h13, 1,0,8'h00, 16'd5);
    tbl[12] = mk(1,0,16'h0000, 1,1,16'h0010,8'h3C, 1,8'h14, 0,0,8'h00, 16'd5);
    tbl[13] = mk(1,1,16'h0010, 0,0,16'h0000,8'h00, 0,8'h00, 0,0,8'h00, 16'd5);
    tbl[14] = mk(1,1,16'h0020, 0,0,16'h0000,8'h00, 0,8'h00, 0,0,8'h00, 16'd5);
    tbl[15] = mk(1,0,16'h0000, 1,1,16'h0020,8'h77, 1,8'h3C, 1,0,8'h00, 16'd5);
    tbl[16] = mk(1,0,16'h0000, 1,1,16'h0020,8'h77, 1,8'h20, 0,0,8'h00, 16'd5);
    tbl[17] = mk(0,0,16'h0000, 0,0,16'h0000,8'h00, 0,8'h00, 0,0,8'h00, 16'd5);

    for (int i = 0; i < 65536; i++) ram_model[i] = 8'(i);

    // ---------------- reset state ----------------
    rst = 1'b0;
    disp_en = 0; disp_req = 0; disp_addr = '0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset.disp_valid", disp_valid, 0);
    check("reset.disp_data", disp_data, 0);
    check("reset.cpu_ack", cpu_ack, 0);
    check("reset.cpu_rdata", cpu_rdata, 0);
    check("reset.stall", cpu_stall_cnt, 0);
    check("reset.mem_addr", mem_addr, 0);
    check("reset.mem_we", mem_we, 0);
    check("reset.mem_wdata", mem_wdata, 0);
    check("reset.stall4", s_stall, 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    // ---------------- table-driven vectors ----------------
    for (int r = 0; r < 18; r++) begin
      drive(tbl[r].den, tbl[r].dreq, tbl[r].daddr,
            tbl[r].creq, tbl[r].cwe, tbl[r].caddr, tbl[r].cwd);
      check($sformatf("tbl%0d.disp_valid", r), disp_valid, tbl[r].e_dv);
      if (tbl[r].e_dv) check($sformatf("tbl%0d.disp_data", r), disp_data, tbl[r].e_dd);
      check($sformatf("tbl%0d.cpu_ack", r), cpu_ack, tbl[r].e_ack);
      if (tbl[r].e_rdchk) check($sformatf("tbl%0d.cpu_rdata", r), cpu_rdata, tbl[r].e_rd);
      check($sformatf("tbl%0d.stall", r), cpu_stall_cnt, tbl[r].e_stall);
    end
    // Idle slots keep the last granted address with the write dropped.
    check("idle.mem_addr_hold", mem_addr, 16'h0020);
    check("idle.mem_we_low", mem_we, 0);

    // ---------------- display burst 0x0100..0x0107 ----------------
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, 1'(i < 8), 16'(256 + i), 1'b0, 1'b0, 16'h0, 8'h00);
      if (i + 1 >= 3 && i + 1 <= 10) begin
        check("burst.disp_valid", disp_valid, 1);
        check("burst.disp_data", disp_data, 32'(i - 2));
      end else begin
        check("burst.disp_valid_gap", disp_valid, 0);
      end
    end

    // ---------------- reset mid-read ----------------
    drive(1'b1, 1'b1, 16'h0105, 1'b0, 1'b0, 16'h0, 8'h00);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    check("midrst.disp_valid", disp_valid, 0);
    check("midrst.disp_data", disp_data, 0);
    check("midrst.cpu_ack", cpu_ack, 0);
    check("midrst.cpu_rdata", cpu_rdata, 0);
    check("midrst.stall", cpu_stall_cnt, 0);
    check("midrst.mem_addr", mem_addr, 0);
    check("midrst.mem_we", mem_we, 0);
    check("midrst.mem_wdata", mem_wdata, 0);
    cpu_req = 1'b0; disp_req = 1'b0; disp_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h00);
      check("postrst.no_valid", disp_valid, 0);
      check("postrst.no_ack", cpu_ack, 0);
    end

    // ---------------- display disabled ----------------
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'(i % 2), 16'(256 + i), 1'(i <= 3), 1'b0, 16'h1234, 8'h00);
      check("dis.no_valid", disp_valid, 0);
      check("dis.cpu_ack", cpu_ack, 32'(i + 1 == 3));
      if (i + 1 == 3) check("dis.cpu_rdata", cpu_rdata, 8'hA5);
    end
    check("dis.no_stall", cpu_stall_cnt, 0);

    // ---------------- stall saturation ----------------
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 16'(512 + i), 1'b1, 1'b1, 16'h0300, 8'h55);
    check("sat.stall4", s_stall, 15);
    check("sat.stall16", cpu_stall_cnt, 20);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0300, 8'h55);
    check("sat.write_ack", cpu_ack, 1);
    drive(1'b1, 1'b0, 16'h0, 1'b1, 1'b1, 16'h0300, 8'h55);
    idle(4);

    // ---------------- randomized traffic vs model ----------------
    c_active = 0; c_we = 0; ack_seen = 0; r_den = 1; c_addr = '0; c_wd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (cpu_ack) begin
        ack_seen = 1'b1;
      end else begin
        if (ack_seen) begin
          c_active = 1'b0;
          ack_seen = 1'b0;
        end
        if (!c_active && $urandom_range(0, 2) == 0) begin
          c_active = 1'b1;
          c_we     = 1'($urandom_range(0, 1));
          c_addr   = 16'($urandom_range(0, 63));
          c_wd     = 8'($urandom_range(0, 255));
        end
      end
      if ($urandom_range(0, 63) == 0) r_den = !r_den;
      drive(r_den, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
            c_active, c_we, c_addr, c_wd);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port frame-buffer arbiter between the VGA pixel fetch path and the CPU's vector-encryption result writer. The display side gets fixed-latency reads with strict priority so scan-out never glitches. The CPU gets the remaining memory slots through a req/ack handshake. The block drives a 64K x 8 synchronous RAM and runs on the single system clock.

## Interface
Parameters:
- ADDR_W, 16, frame-buffer address width (matches display read address)
- DATA_W, 8, pixel width
- STALL_W, 16, width of saturating CPU stall counter

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- disp_en  in  1  display fetch enable; low = all slots to CPU, disp_req ignored
- disp_req  in  1  display read request, single-cycle qualifier
- disp_addr  in  ADDR_W  display read address
- disp_valid  out  1  display read data valid
- disp_data  out  DATA_W  display read data
- cpu_req  in  1  CPU request, held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req high
- cpu_wdata  in  DATA_W  CPU write data; stable while cpu_req high
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack for reads
- cpu_stall_cnt  out  STALL_W  saturating count of cycles cpu_req lost arbitration
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, one cycle after address (registered RAM)

## Operation
- Slot grant, evaluated each cycle T:
  - If disp_en and disp_req, the display wins.
  - Otherwise, if cpu_req and the CPU FSM is in C_IDLE, the CPU wins.
  - Otherwise the slot is idle.
- The granted request is registered onto mem_* at T+1. An idle slot drives mem_we = 0 and holds the last mem_addr.
- Display pipeline: a 2-bit tag shift register marks display reads in flight. At T+3, disp_data <= mem_rdata and disp_valid = 1.
- CPU FSM:
  - States: C_IDLE, C_WR, C_RD1, C_RD2.
  - C_IDLE -> C_WR on a write grant. C_WR asserts cpu_ack in the cycle mem_we is high (T+1), then returns to C_IDLE.
  - C_IDLE -> C_RD1 on a read grant; C_RD1 -> C_RD2.
  - In C_RD2, cpu_rdata <= mem_rdata, cpu_ack pulses at T+3, then return to C_IDLE.
  - No new CPU grant is made outside C_IDLE. Display grants continue during C_RD1 and C_RD2.
- cpu_req still high in the cycle after cpu_ack is a new transaction.
- Stall counter: increments when cpu_req = 1, FSM = C_IDLE, and the display wins. It saturates at all-ones and does not wrap.
- Ordering follows issue order. A display read issued before a CPU write to the same address returns the old data.
- disp_en falling mid-fetch: in-flight display reads still complete and assert disp_valid.

## Timing
- Reset values: disp_valid = 0, disp_data = 0, cpu_ack = 0, cpu_rdata = 0, cpu_stall_cnt = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0. FSM = C_IDLE, tags cleared.
- Display read latency: 3 cycles from disp_req to disp_valid. Throughput is one per cycle.
- CPU write: ack at T+1 from grant. CPU read: ack at T+3 from grant.
- Minimum CPU read period is 4 cycles.
- Simultaneous disp_req and cpu_req: display wins and the stall counter increments. The CPU retries automatically every cycle while req is held.
- Reset mid-operation: all in-flight transactions are dropped and no ack is issued. The CPU must re-request after reset deasserts.
- A display requesting every cycle starves the CPU by design. The system guarantees blanking intervals.

## Test plan
- Reset: assert rst = 0 mid-read. All outputs are 0 at once, with no cpu_ack or disp_valid after release.
- CPU write then read: write addr 0x1234 data 0xA5 gives ack at T+1. A read of 0x1234 gives ack at T+3 with cpu_rdata = 0xA5.
- Display burst: RAM preloaded with addr[7:0]; disp_req on 8 consecutive cycles from addr 0x0100. disp_valid runs for 8 consecutive cycles starting 3 cycles later, with data 0x00..0x07.
- Contention: cpu_req write held during a 5-cycle display burst. The write issues on the first idle slot, cpu_stall_cnt = 5, and display data is unaffected.
- Display disabled: disp_en = 0 with disp_req toggling. There is no disp_valid, and a CPU read acks at T+3 with no stalls counted.
- Stall saturation: STALL_W = 4 with 20 contended cycles leaves cpu_stall_cnt = 15.
